// File: rtl/maze_walker_ctrl.sv
// Depth-first maze solver: walks a ROWS x COLS bit-map over a req/ack port and replays the path.
// Optional step limit is compiled in when MAZE_STEP_LIMIT_EN is defined.
module maze_walker_ctrl #(
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int DEPTH     = 256,
  parameter int MAX_STEPS = 1024,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 run,
  output logic [RW+CW-1:0]     mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 mem_wdata,
  input  logic                 mem_rdata,
  input  logic                 mem_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic                 path_valid,
  input  logic                 path_ready,
  output logic [RW-1:0]        path_row,
  output logic [CW-1:0]        path_col,
  output logic                 path_last,
  output logic [15:0]          step_count
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int EW  = RW + CW + 2;
  localparam logic [RW-1:0]  ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0]  COL_MAX = CW'(COLS - 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ARM       = 4'd1,
    S_MARK      = 4'd2,
    S_CHECK     = 4'd3,
    S_PROBE     = 4'd4,
    S_RDWAIT    = 4'd5,
    S_PUSH      = 4'd6,
    S_NEXTDIR   = 4'd7,
    S_BACKTRACK = 4'd8,
    S_DONE      = 4'd9,
    S_REPLAY    = 4'd10,
    S_FAIL      = 4'd11
  } state_t;

  state_t          state_r, nxt_state_s;
  logic [RW-1:0]   row_r, nxt_row_s, nrow_r, nxt_nrow_s, prow_s;
  logic [CW-1:0]   col_r, nxt_col_s, ncol_r, nxt_ncol_s, pcol_s;
  logic [1:0]      dir_r, nxt_dir_s;
  logic [SPW-1:0]  sp_r, nxt_sp_s, rp_r, nxt_rp_s, sp_dec_s;
  logic [15:0]     step_r, nxt_step_s, step_inc_s;
  logic            probe_ok_s, push_s, limit_hit_s;
  logic [EW-1:0]   stack_mem [DEPTH];
  logic [EW-1:0]   pop_s, beat_s;

  logic [RW+CW-1:0] mem_addr_r, nxt_mem_addr_s;
  logic             mem_rd_r, mem_wr_r, mem_wdata_r, busy_r, done_r, fail_r;
  logic             path_valid_r, path_last_r, nxt_last_s;
  logic [RW-1:0]    path_row_r, nxt_path_row_s;
  logic [CW-1:0]    path_col_r, nxt_path_col_s;

`ifdef MAZE_STEP_LIMIT_EN
  localparam logic [15:0] STEP_LIMIT = 16'(MAX_STEPS);
  assign limit_hit_s = (step_r == STEP_LIMIT);
`else
  assign limit_hit_s = 1'b0;
`endif

  assign step_inc_s = (step_r == 16'hFFFF) ? step_r : step_r + 16'd1;
  assign sp_dec_s   = sp_r - SPW'(1);
  assign pop_s      = stack_mem[sp_dec_s[AW-1:0]];
  assign beat_s     = stack_mem[nxt_rp_s[AW-1:0]];

  // Neighbour of the current cell in direction dir, with bounds check.
  always_comb begin
    probe_ok_s = 1'b0;
    prow_s     = row_r;
    pcol_s     = col_r;
    case (dir_r)
      2'd0: begin
        probe_ok_s = (row_r != {RW{1'b0}});
        prow_s     = row_r - RW'(1);
      end
      2'd1: begin
        probe_ok_s = (col_r != COL_MAX);
        pcol_s     = col_r + CW'(1);
      end
      2'd2: begin
        probe_ok_s = (col_r != {CW{1'b0}});
        pcol_s     = col_r - CW'(1);
      end
      2'd3: begin
        probe_ok_s = (row_r != ROW_MAX);
        prow_s     = row_r + RW'(1);
      end
      default: probe_ok_s = 1'b0;
    endcase
  end

  // Search / replay next-state logic.
  always_comb begin
    nxt_state_s = state_r;
    nxt_row_s   = row_r;
    nxt_col_s   = col_r;
    nxt_dir_s   = dir_r;
    nxt_nrow_s  = nrow_r;
    nxt_ncol_s  = ncol_r;
    nxt_sp_s    = sp_r;
    nxt_rp_s    = rp_r;
    nxt_step_s  = step_r;
    push_s      = 1'b0;
    case (state_r)
      S_IDLE, S_FAIL: begin
        if (start) nxt_state_s = S_ARM;
        else       nxt_state_s = state_r;
      end
      S_ARM: begin
        if (!start) begin
          nxt_row_s   = {RW{1'b0}};
          nxt_col_s   = {CW{1'b0}};
          nxt_dir_s   = 2'd0;
          nxt_sp_s    = {SPW{1'b0}};
          nxt_step_s  = 16'd0;
          nxt_state_s = S_MARK;
        end else begin
          nxt_state_s = S_ARM;
        end
      end
      S_MARK: begin
        if (mem_ack) nxt_state_s = S_CHECK;
        else         nxt_state_s = S_MARK;
      end
      S_CHECK: begin
        if (row_r == ROW_MAX && col_r == COL_MAX) begin
          nxt_state_s = S_DONE;
        end else begin
          nxt_dir_s   = 2'd0;
          nxt_state_s = S_PROBE;
        end
      end
      S_PROBE: begin
        if (probe_ok_s) begin
          nxt_nrow_s  = prow_s;
          nxt_ncol_s  = pcol_s;
          nxt_state_s = S_RDWAIT;
        end else begin
          nxt_state_s = S_NEXTDIR;
        end
      end
      S_RDWAIT: begin
        if (!mem_ack)      nxt_state_s = S_RDWAIT;
        else if (mem_rdata) nxt_state_s = S_NEXTDIR;
        else               nxt_state_s = S_PUSH;
      end
      S_PUSH: begin
        if (limit_hit_s || sp_r == SP_FULL) begin
          nxt_state_s = S_FAIL;
        end else begin
          push_s      = 1'b1;
          nxt_row_s   = nrow_r;
          nxt_col_s   = ncol_r;
          nxt_sp_s    = sp_r + SPW'(1);
          nxt_step_s  = step_inc_s;
          nxt_state_s = S_MARK;
        end
      end
      S_NEXTDIR: begin
        if (dir_r != 2'd3) begin
          nxt_dir_s   = dir_r + 2'd1;
          nxt_state_s = S_PROBE;
        end else begin
          nxt_state_s = S_BACKTRACK;
        end
      end
      S_BACKTRACK: begin
        if (limit_hit_s || sp_r == {SPW{1'b0}}) begin
          nxt_state_s = S_FAIL;
        end else begin
          nxt_row_s   = pop_s[EW-1 -: RW];
          nxt_col_s   = pop_s[CW+1 -: CW];
          nxt_dir_s   = pop_s[1:0];
          nxt_sp_s    = sp_dec_s;
          nxt_step_s  = step_inc_s;
          nxt_state_s = S_NEXTDIR;
        end
      end
      S_DONE: begin
        if (start) begin
          nxt_state_s = S_ARM;
        end else if (run) begin
          nxt_rp_s    = {SPW{1'b0}};
          nxt_state_s = S_REPLAY;
        end else begin
          nxt_state_s = S_DONE;
        end
      end
      S_REPLAY: begin
        if (path_valid_r && path_ready && path_last_r) nxt_state_s = S_IDLE;
        else if (path_valid_r && path_ready)           nxt_rp_s    = rp_r + SPW'(1);
        else                                           nxt_state_s = S_REPLAY;
      end
      default: nxt_state_s = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    if (nxt_state_s == S_RDWAIT)    nxt_mem_addr_s = {nxt_nrow_s, nxt_ncol_s};
    else if (nxt_state_s == S_MARK) nxt_mem_addr_s = {nxt_row_s, nxt_col_s};
    else                            nxt_mem_addr_s = {(RW+CW){1'b0}};
    nxt_last_s = (nxt_state_s == S_REPLAY) && (nxt_rp_s == nxt_sp_s);
    if (nxt_state_s != S_REPLAY) begin
      nxt_path_row_s = {RW{1'b0}};
      nxt_path_col_s = {CW{1'b0}};
    end else if (nxt_last_s) begin
      nxt_path_row_s = ROW_MAX;
      nxt_path_col_s = COL_MAX;
    end else begin
      nxt_path_row_s = beat_s[EW-1 -: RW];
      nxt_path_col_s = beat_s[CW+1 -: CW];
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      row_r        <= {RW{1'b0}};
      col_r        <= {CW{1'b0}};
      dir_r        <= 2'd0;
      nrow_r       <= {RW{1'b0}};
      ncol_r       <= {CW{1'b0}};
      sp_r         <= {SPW{1'b0}};
      rp_r         <= {SPW{1'b0}};
      step_r       <= 16'd0;
      mem_addr_r   <= {(RW+CW){1'b0}};
      mem_rd_r     <= 1'b0;
      mem_wr_r     <= 1'b0;
      mem_wdata_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      fail_r       <= 1'b0;
      path_valid_r <= 1'b0;
      path_last_r  <= 1'b0;
      path_row_r   <= {RW{1'b0}};
      path_col_r   <= {CW{1'b0}};
    end else begin
      state_r      <= nxt_state_s;
      row_r        <= nxt_row_s;
      col_r        <= nxt_col_s;
      dir_r        <= nxt_dir_s;
      nrow_r       <= nxt_nrow_s;
      ncol_r       <= nxt_ncol_s;
      sp_r         <= nxt_sp_s;
      rp_r         <= nxt_rp_s;
      step_r       <= nxt_step_s;
      mem_addr_r   <= nxt_mem_addr_s;
      mem_rd_r     <= (nxt_state_s == S_RDWAIT);
      mem_wr_r     <= (nxt_state_s == S_MARK);
      mem_wdata_r  <= 1'b1;
      busy_r       <= (nxt_state_s != S_IDLE) && (nxt_state_s != S_DONE) && (nxt_state_s != S_FAIL);
      done_r       <= (nxt_state_s == S_DONE);
      fail_r       <= (nxt_state_s == S_FAIL);
      path_valid_r <= (nxt_state_s == S_REPLAY);
      path_last_r  <= nxt_last_s;
      path_row_r   <= nxt_path_row_s;
      path_col_r   <= nxt_path_col_s;
    end
  end

  // Path stack storage; contents need no reset because sp gates every read.
  always_ff @(posedge clk) begin
    if (push_s) stack_mem[sp_r[AW-1:0]] <= {row_r, col_r, dir_r};
  end

  assign mem_addr   = mem_addr_r;
  assign mem_rd     = mem_rd_r;
  assign mem_wr     = mem_wr_r;
  assign mem_wdata  = mem_wdata_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign fail       = fail_r;
  assign path_valid = path_valid_r;
  assign path_row   = path_row_r;
  assign path_col   = path_col_r;
  assign path_last  = path_last_r;
  assign step_count = step_r;

endmodule

// File: tb/tb_maze_walker_ctrl.sv
// Scoreboard bench for maze_walker_ctrl: 2x2 maze with a latency-configurable memory model
// plus a 1x1 instance for the start==goal case.
`timescale 1ns/1ps
module tb_maze_walker_ctrl;

`ifdef MAZE_STEP_LIMIT_EN
  localparam int MAXS = 1;
`else
  localparam int MAXS = 1024;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, run = 1'b0, path_ready = 1'b0;
  logic [1:0] mem_addr;
  logic mem_rd, mem_wr, mem_wdata, mem_rdata, mem_ack;
  logic busy, done, fail, path_valid, path_last;
  logic [0:0] path_row, path_col;
  logic [15:0] step_count;

  logic start1 = 1'b0, run1 = 1'b0, ready1 = 1'b0;
  logic [1:0] addr1;
  logic rd1, wr1, wdata1, ack1, busy1, done1, fail1, valid1, last1;
  logic [0:0] row1, col1;
  logic [15:0] step1;

  logic [3:0] walls = 4'b0000;
  logic [3:0] visited;
  int ack_delay = 0;
  int ack_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int beat_cnt = 0;
  int valid_cnt = 0;
  int wr1_cnt = 0;
  int rd1_cnt = 0;
  logic prev_req, prev_ack;

  logic [2:0] acc_q[$];
  logic [2:0] beat_q[$];

  always #5 clk = ~clk;

  maze_walker_ctrl #(.ROWS(2), .COLS(2), .DEPTH(8), .MAX_STEPS(MAXS)) u_dut (
    .clk(clk), .rst(rst), .start(start), .run(run),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .fail(fail),
    .path_valid(path_valid), .path_ready(path_ready),
    .path_row(path_row), .path_col(path_col), .path_last(path_last),
    .step_count(step_count)
  );

  maze_walker_ctrl #(.ROWS(1), .COLS(1), .DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .run(run1),
    .mem_addr(addr1), .mem_rd(rd1), .mem_wr(wr1), .mem_wdata(wdata1),
    .mem_rdata(1'b0), .mem_ack(ack1),
    .busy(busy1), .done(done1), .fail(fail1),
    .path_valid(valid1), .path_ready(ready1),
    .path_row(row1), .path_col(col1), .path_last(last1),
    .step_count(step1)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Maze memory: walls plus visited marks, ack after ack_delay+1 cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_ack   <= 1'b0;
      mem_rdata <= 1'b0;
      ack_cnt   <= 0;
      visited   <= 4'b0000;
    end else begin
      mem_ack <= 1'b0;
      if (start) visited <= 4'b0000;
      if (mem_ack) begin
        ack_cnt <= 0;
      end else if (mem_rd || mem_wr) begin
        if (ack_cnt >= ack_delay) begin
          mem_ack <= 1'b1;
          if (mem_wr) visited[mem_addr] <= mem_wdata;
          else        mem_rdata <= walls[mem_addr] | visited[mem_addr];
        end else begin
          ack_cnt <= ack_cnt + 1;
        end
      end
    end
  end

  // Trivial memory for the 1x1 instance.
  always @(posedge clk or negedge rst) begin
    if (!rst) ack1 <= 1'b0;
    else      ack1 <= (rd1 | wr1) & ~ack1;
  end

  // Memory-access and replay scoreboards, sampled on the falling edge.
  always @(negedge clk) begin : mon
    logic [3:0] exp_acc, exp_beat;
    if (!rst) begin
      prev_req <= 1'b0;
      prev_ack <= 1'b0;
    end else begin
      exp_acc  = (acc_q.size() != 0) ? {1'b1, acc_q[0]} : 4'b0000;
      exp_beat = (beat_q.size() != 0) ? {1'b1, beat_q[0]} : 4'b0000;
      if (prev_req && !prev_ack) check_value("req_held", 32'(mem_rd | mem_wr), 32'd1);
      if (mem_rd || mem_wr) begin
        check_value("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
        check_value("mem_req", 32'({1'b1, mem_wr, mem_addr}), 32'(exp_acc));
        if (mem_wr) check_value("wdata", 32'(mem_wdata), 32'd1);
        if (mem_ack && acc_q.size() != 0) void'(acc_q.pop_front());
      end
      prev_req <= mem_rd | mem_wr;
      prev_ack <= mem_ack;
      if (path_valid) begin
        valid_cnt <= valid_cnt + 1;
        if (path_ready) begin
          check_value("beat", 32'({path_valid, path_row, path_col, path_last}), 32'(exp_beat));
          if (beat_q.size() != 0) void'(beat_q.pop_front());
          beat_cnt <= beat_cnt + 1;
        end else begin
          check_value("beat_stall", 32'({path_valid, path_row, path_col, path_last}), 32'(exp_beat));
        end
      end
      if (ack1 && wr1) wr1_cnt <= wr1_cnt + 1;
      if (ack1 && rd1) rd1_cnt <= rd1_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) check_value("solve_timeout", 32'(busy), 32'd0);
  endtask

  task automatic push_ok_accesses();
    acc_q.push_back(3'b100);
    acc_q.push_back(3'b001);
    acc_q.push_back(3'b101);
    acc_q.push_back(3'b000);
    acc_q.push_back(3'b011);
    acc_q.push_back(3'b111);
  endtask

  task automatic replay(input bit stall);
    int n = 0;
    int base;
    bit stalled = 1'b0;
    base = beat_cnt;
    beat_q.push_back(3'b000);
    beat_q.push_back(3'b010);
    beat_q.push_back(3'b111);
    path_ready = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    while ((busy || beat_q.size() != 0) && n < 100) begin
      if (stall && !stalled && beat_cnt == base + 1) begin
        path_ready = 1'b0;
        repeat (3) tick();
        path_ready = 1'b1;
        stalled = 1'b1;
      end
      tick();
      n++;
    end
    check_value("replay_drain", 32'(beat_q.size()), 32'd0);
    check_value("beat_count", 32'(beat_cnt - base), 32'd3);
    check_value("idle_after_replay", 32'({busy, done, fail, path_valid}), 32'd0);
  endtask

  task automatic solve_ok(input int dly, input bit stall);
    walls = 4'b0000;
    ack_delay = dly;
    push_ok_accesses();
    pulse_start();
    wait_idle(500);
    check_value("ok_flags", 32'({busy, done, fail, path_valid}), 32'b0100);
    check_value("ok_steps", 32'(step_count), 32'd2);
    check_value("ok_accesses", 32'(acc_q.size()), 32'd0);
    replay(stall);
  endtask

  initial begin : main
    int base;
    int n;
    tick();
    check_value("reset_outs",
      32'({mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, fail, path_valid, path_row, path_col, path_last, step_count}),
      32'd0);
    check_value("reset_outs1", 32'({rd1, wr1, busy1, done1, fail1, valid1, step1}), 32'd0);
    rst = 1'b1;
    tick();

`ifdef MAZE_STEP_LIMIT_EN
    base = valid_cnt;
    walls = 4'b0000;
    acc_q.push_back(3'b100);
    acc_q.push_back(3'b001);
    acc_q.push_back(3'b101);
    acc_q.push_back(3'b000);
    acc_q.push_back(3'b011);
    pulse_start();
    wait_idle(500);
    check_value("limit_flags", 32'({busy, done, fail}), 32'b001);
    check_value("limit_steps", 32'(step_count), 32'd1);
    check_value("limit_accesses", 32'(acc_q.size()), 32'd0);
    check_value("limit_no_valid", 32'(valid_cnt - base), 32'd0);
`else
    solve_ok(0, 1'b0);

    base = valid_cnt;
    walls = 4'b0110;
    ack_delay = 0;
    acc_q.push_back(3'b100);
    acc_q.push_back(3'b001);
    acc_q.push_back(3'b010);
    pulse_start();
    wait_idle(500);
    run = 1'b1;
    repeat (3) tick();
    run = 1'b0;
    tick();
    check_value("wall_flags", 32'({busy, done, fail}), 32'b001);
    check_value("wall_steps", 32'(step_count), 32'd0);
    check_value("wall_accesses", 32'(acc_q.size()), 32'd0);
    check_value("wall_no_valid", 32'(valid_cnt - base), 32'd0);

    solve_ok(0, 1'b0);
    solve_ok(5, 1'b0);
    solve_ok(0, 1'b1);

    walls = 4'b0000;
    ack_delay = 5;
    push_ok_accesses();
    pulse_start();
    n = 0;
    while (!mem_rd && n < 60) begin
      tick();
      n++;
    end
    check_value("reach_rdwait", 32'(mem_rd), 32'd1);
    #1 rst = 1'b0;
    #1;
    check_value("async_reset_outs",
      32'({mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, fail, path_valid, path_row, path_col, path_last, step_count}),
      32'd0);
    acc_q.delete();
    tick();
    rst = 1'b1;
    tick();
    solve_ok(0, 1'b0);
`endif

    start1 = 1'b1;
    tick();
    tick();
    start1 = 1'b0;
    n = 0;
    tick();
    while (busy1 && n < 50) begin
      tick();
      n++;
    end
    check_value("one_flags", 32'({busy1, done1, fail1}), 32'b010);
    check_value("one_steps", 32'(step1), 32'd0);
    check_value("one_writes", 32'(wr1_cnt), 32'd1);
    check_value("one_reads", 32'(rd1_cnt), 32'd0);
    ready1 = 1'b1;
    run1 = 1'b1;
    tick();
    run1 = 1'b0;
    check_value("one_beat", 32'({valid1, row1, col1, last1}), 32'b1001);
    tick();
    check_value("one_after", 32'({valid1, busy1, done1}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
